// File: rtl/order_4_1.sv
// Serialising sorter: captures a 4-word group, then emits it one word per beat in sorted order with original index.
// Define ORDER_4_1_DESCEND_EN for descending order; default build sorts ascending.
module order_4_1 #(
    parameter int unsigned DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] indata0,
    input  logic [DSIZE-1:0] indata1,
    input  logic [DSIZE-1:0] indata2,
    input  logic [DSIZE-1:0] indata3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] outdata,
    output logic [1:0]       outindex,
    output logic             outlast
);

    localparam int unsigned NUM  = 4;
    localparam int unsigned IDXW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [NUM-1:0][DSIZE-1:0]   group_q, group_d;
    logic [NUM-1:0]              used_q, used_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [DSIZE-1:0]            outdata_q, outdata_d;
    logic [IDXW-1:0]             outindex_q, outindex_d;
    logic                        outlast_q, outlast_d;

    logic [NUM-1:0][DSIZE-1:0]   in_group;
    logic [NUM-1:0]              used_after;
    logic [IDXW-1:0]             sel_in;
    logic [IDXW-1:0]             sel_emit;
    logic                        capture;
    logic                        accept;

    // Strict compare so that on ties the earlier (lower) index is kept.
    function automatic logic better(input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b);
`ifdef ORDER_4_1_DESCEND_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    function automatic logic [IDXW-1:0] pick(input logic [NUM-1:0][DSIZE-1:0] w,
                                             input logic [NUM-1:0] used);
        logic             found;
        logic [IDXW-1:0]  idx;
        logic [DSIZE-1:0] best;
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (!used[i] && (!found || better(w[i], best))) begin
                found = 1'b1;
                idx   = IDXW'(i);
                best  = w[i];
            end
        end
        return idx;
    endfunction

    assign in_group   = {indata3, indata2, indata1, indata0};
    assign used_after = used_q | (4'b0001 << outindex_q);
    assign sel_in     = pick(in_group, '0);
    assign sel_emit   = pick(group_q, used_after);
    assign capture    = (state_q == IDLE) && in_valid && in_ready_q;
    assign accept     = out_valid_q && out_ready;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = EMIT;
            EMIT:    if (accept && outlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        group_d     = group_q;
        used_d      = used_q;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        outdata_d   = outdata_q;
        outindex_d  = outindex_q;
        outlast_d   = outlast_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (capture) begin
                    group_d     = in_group;
                    used_d      = '0;
                    outdata_d   = in_group[sel_in];
                    outindex_d  = sel_in;
                    outlast_d   = 1'b0;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            EMIT: begin
                if (accept) begin
                    used_d = used_after;
                    if (outlast_q) begin
                        out_valid_d = 1'b0;
                        outlast_d   = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        outdata_d  = group_q[sel_emit];
                        outindex_d = sel_emit;
                        outlast_d  = ($countones(used_after) == 3);
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            group_q     <= '0;
            used_q      <= '1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            outdata_q   <= '0;
            outindex_q  <= '0;
            outlast_q   <= 1'b0;
        end else begin
            group_q     <= group_d;
            used_q      <= used_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            outdata_q   <= outdata_d;
            outindex_q  <= outindex_d;
            outlast_q   <= outlast_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign outdata   = outdata_q;
    assign outindex  = outindex_q;
    assign outlast   = outlast_q;

endmodule

// File: tb/tb_order_4_1.sv
// Self-checking bench for order_4_1: rank-based reference model plus directed test-plan groups and random traffic.
module tb_order_4_1;

    localparam int unsigned DSIZE = 8;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DSIZE-1:0] indata0 = '0, indata1 = '0, indata2 = '0, indata3 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DSIZE-1:0] outdata;
    logic [1:0]       outindex;
    logic             outlast;

    order_4_1 #(.DSIZE(DSIZE)) dut (
        .clock(clock), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .indata0(indata0), .indata1(indata1), .indata2(indata2), .indata3(indata3),
        .out_valid(out_valid), .out_ready(out_ready),
        .outdata(outdata), .outindex(outindex), .outlast(outlast)
    );

    always #5 clock = ~clock;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 1'b0;
    logic [10:0] beats[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on capture, each word's output slot is its rank among the group.
    logic       m_ready, m_ov, m_last;
    logic [7:0] m_data;
    logic [1:0] m_idx;
    int         m_pos;
    logic [7:0] s_d[4];
    logic [1:0] s_i[4];

    function automatic bit goes_before(input logic [7:0] vj, input int j, input logic [7:0] vi, input int i);
`ifdef ORDER_4_1_DESCEND_EN
        return (vj > vi) || (vj == vi && j < i);
`else
        return (vj < vi) || (vj == vi && j < i);
`endif
    endfunction

    always @(posedge clock) begin
        logic [7:0] v[4];
        int r;
        if (rst) begin
            m_ready = 1'b0; m_ov = 1'b0; m_last = 1'b0; m_data = '0; m_idx = '0; m_pos = 0;
        end else if (m_ov) begin
            if (out_ready) begin
                if (m_pos == 3) begin
                    m_ov = 1'b0; m_last = 1'b0; m_ready = 1'b1;
                end else begin
                    m_pos++;
                    m_data = s_d[m_pos]; m_idx = s_i[m_pos]; m_last = (m_pos == 3);
                end
            end
        end else if (m_ready && in_valid) begin
            v[0] = indata0; v[1] = indata1; v[2] = indata2; v[3] = indata3;
            for (int i = 0; i < 4; i++) begin
                r = 0;
                for (int j = 0; j < 4; j++) if (j != i && goes_before(v[j], j, v[i], i)) r++;
                s_d[r] = v[i];
                s_i[r] = 2'(i);
            end
            m_pos = 0; m_data = s_d[0]; m_idx = s_i[0];
            m_ov = 1'b1; m_ready = 1'b0; m_last = 1'b0;
        end else begin
            m_ready = 1'b1;
        end
    end

    // Per-cycle comparison against the model, and log of accepted beats.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("outdata", 32'(outdata), 32'(m_data));
                chk("outindex", 32'(outindex), 32'(m_idx));
                chk("outlast", 32'(outlast), 32'(m_last));
            end else begin
                chk("outlast_idle", 32'(outlast), 32'd0);
            end
            if (out_valid === 1'b1 && out_ready && !rst) beats.push_back({outlast, outindex, outdata});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input bit hold);
        int t = 0;
        beats.delete();
        while (in_ready !== 1'b1 && t < 30) begin step(); t++; end
        if (t >= 30) chk("wait_in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1; indata0 = a; indata1 = b; indata2 = c; indata3 = d;
        out_ready = 1'b1;
        step();
        if (hold) begin
            indata0 = 8'd1; indata1 = 8'd1; indata2 = 8'd1; indata3 = 8'd1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic collect(input int n);
        int t = 0;
        while (beats.size() < n && t < 80) begin step(); t++; end
        chk("beat_count", 32'(beats.size()), 32'(n));
    endtask

    task automatic check_beats(input string name, input int base,
                               input logic [31:0] ed, input logic [7:0] ei);
        logic [10:0] b;
        for (int k = 0; k < 4; k++) begin
            b = (beats.size() > base + k) ? beats[base + k] : 11'h7ff;
            chk({name, "_data"}, 32'(b[7:0]), 32'(ed[31 - 8 * k -: 8]));
            chk({name, "_index"}, 32'(b[9:8]), 32'(ei[7 - 2 * k -: 2]));
            chk({name, "_last"}, 32'(b[10]), 32'(k == 3));
        end
    endtask

    initial begin
        int k;
        logic [31:0] e1d, e2d, e3d, e4d, e5d;
        logic [7:0]  e1i, e2i, e3i, e4i, e5i;
`ifdef ORDER_4_1_DESCEND_EN
        e1d = {8'd9, 8'd7, 8'd3, 8'd3};     e1i = {2'd2, 2'd0, 2'd1, 2'd3};
        e2d = {8'd5, 8'd4, 8'd2, 8'd1};     e2i = {2'd0, 2'd2, 2'd3, 2'd1};
        e3d = {8'd255, 8'd128, 8'd0, 8'd0}; e3i = {2'd0, 2'd2, 2'd1, 2'd3};
        e4d = {8'd3, 8'd2, 8'd1, 8'd0};     e4i = {2'd2, 2'd0, 2'd3, 2'd1};
`else
        e1d = {8'd3, 8'd3, 8'd7, 8'd9};     e1i = {2'd1, 2'd3, 2'd0, 2'd2};
        e2d = {8'd1, 8'd2, 8'd4, 8'd5};     e2i = {2'd1, 2'd3, 2'd2, 2'd0};
        e3d = {8'd0, 8'd0, 8'd128, 8'd255}; e3i = {2'd1, 2'd3, 2'd2, 2'd0};
        e4d = {8'd0, 8'd1, 8'd2, 8'd3};     e4i = {2'd1, 2'd3, 2'd0, 2'd2};
`endif
        e5d = {8'd6, 8'd6, 8'd6, 8'd6};     e5i = {2'd0, 2'd1, 2'd2, 2'd3};

        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outdata", 32'(outdata), 32'd0);
        chk("rst_outindex", 32'(outindex), 32'd0);
        chk("rst_outlast", 32'(outlast), 32'd0);
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Full-rate group and group period.
        capture(8'd7, 8'd3, 8'd9, 8'd3, 1'b0);
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin step(); k++; end
        chk("group_period", 32'(k), 32'd4);
        check_beats("g7393", 0, e1d, e1i);

        // Backpressure holds the first beat for three cycles.
        capture(8'd5, 8'd1, 8'd4, 8'd2, 1'b0);
        out_ready = 1'b0;
        repeat (3) begin
            chk("bp_hold_data", 32'(outdata), 32'(e2d[31:24]));
            chk("bp_hold_index", 32'(outindex), 32'(e2i[7:6]));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        collect(4);
        check_beats("g5142", 0, e2d, e2i);

        // All-equal group with a second group held on the input during emission.
        capture(8'd6, 8'd6, 8'd6, 8'd6, 1'b1);
        collect(8);
        in_valid = 1'b0;
        check_beats("g6666", 0, e5d, e5i);
        check_beats("g1111", 4, {8'd1, 8'd1, 8'd1, 8'd1}, e5i);

        capture(8'd255, 8'd0, 8'd128, 8'd0, 1'b0);
        collect(4);
        check_beats("gext", 0, e3d, e3i);

        // Reset after the second beat discards the group.
        capture(8'd9, 8'd8, 8'd7, 8'd6, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_outdata", 32'(outdata), 32'd0);
        chk("midrst_outindex", 32'(outindex), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        capture(8'd2, 8'd0, 8'd3, 8'd1, 1'b0);
        collect(4);
        check_beats("g2031", 0, e4d, e4i);

        // Random traffic with ties, backpressure and occasional reset.
        repeat (2000) begin
            in_valid  = ($urandom % 3) != 0;
            indata0   = ($urandom % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            indata1   = ($urandom % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            indata2   = ($urandom % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            indata3   = ($urandom % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 250) == 0;
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
